// File: rtl/datapath_bus.sv
// Register-file/bus datapath steered by the controller's control word.
// One source drives the shared bus per cycle; registers load, increment or clear from it.
module datapath_bus #(
    parameter int DW  = 16,
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2:0]     alu_op,
    input  logic [15:0]    write_en,
    input  logic [15:0]    inc_en,
    input  logic [15:0]    clr_en,
    input  logic [3:0]     read_en,
    input  logic [DW-1:0]  im_rdata,
    input  logic [DW-1:0]  dm_rdata,
    output logic [DW-1:0]  im_addr,
    output logic [DW-1:0]  dm_addr,
    output logic [DW-1:0]  dm_wdata,
    output logic           dm_we,
    output logic [OPW-1:0] instruction,
    output logic [15:0]    z,
    output logic [DW-1:0]  bus
);

    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_MULT   = 3'd3;
    localparam logic [2:0] ALU_LSHIFT = 3'd4;

    logic [DW-1:0] pc, ar, ir, ac, r, r1, r2, r3, r4, r5;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] ac_next;

    function automatic logic [DW-1:0] next_reg(
        input logic [DW-1:0] cur,
        input logic          clr,
        input logic          wr,
        input logic          inc,
        input logic [DW-1:0] d
    );
        if (clr)
            return '0;
        else if (wr)
            return d;
        else if (inc)
            return cur + DW'(1);
        else
            return cur;
    endfunction

    always_comb begin
        bus = '0;
        case (read_en)
            4'd1:    bus = pc;
            4'd2:    bus = ar;
            4'd4:    bus = ir;
            4'd5:    bus = ac;
            4'd6:    bus = r;
            4'd7:    bus = r1;
            4'd8:    bus = r2;
            4'd9:    bus = r3;
            4'd10:   bus = r4;
            4'd11:   bus = r5;
            4'd12:   bus = dm_rdata;
            4'd13:   bus = im_rdata;
            default: bus = '0;
        endcase
    end

    always_comb begin
        alu_result = ac;
        case (alu_op)
            ALU_ADD:    alu_result = ac + r;
            ALU_SUB:    alu_result = ac - r;
            ALU_MULT:   alu_result = ac * r;
            ALU_LSHIFT: alu_result = ac << 1;
            default:    alu_result = ac;
        endcase
    end

    // The ALU path into AC outranks a bus load of AC in the same cycle.
    always_comb begin
        if (clr_en[4])
            ac_next = '0;
        else if (write_en[12])
            ac_next = alu_result;
        else
            ac_next = next_reg(ac, 1'b0, write_en[4], inc_en[4], bus);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            ar <= '0;
            ir <= '0;
            ac <= '0;
            r  <= '0;
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
            r4 <= '0;
            r5 <= '0;
        end else begin
            pc <= next_reg(pc, clr_en[1],  write_en[1],  inc_en[1],  bus);
            ar <= next_reg(ar, clr_en[2],  write_en[2],  inc_en[2],  bus);
            ir <= next_reg(ir, clr_en[3],  write_en[3],  inc_en[3],  bus);
            ac <= ac_next;
            r  <= next_reg(r,  clr_en[5],  write_en[5],  inc_en[5],  bus);
            r5 <= next_reg(r5, clr_en[6],  write_en[6],  inc_en[6],  bus);
            r4 <= next_reg(r4, clr_en[7],  write_en[7],  inc_en[7],  bus);
            r3 <= next_reg(r3, clr_en[8],  write_en[8],  inc_en[8],  bus);
            r2 <= next_reg(r2, clr_en[9],  write_en[9],  inc_en[9],  bus);
            r1 <= next_reg(r1, clr_en[10], write_en[10], inc_en[10], bus);
        end
    end

    // Fetch cycle forwards the opcode straight off the bus so the controller can branch immediately.
    assign instruction = write_en[3] ? bus[OPW-1:0] : ir[OPW-1:0];
    assign im_addr     = pc;
    assign dm_addr     = ar;
    assign dm_wdata    = bus;
    assign dm_we       = write_en[11] & rst_n;
    assign z           = {15'b0, (ac == '0)};

    logic unused_bits;
    assign unused_bits = ^{write_en[15:13], write_en[0],
                           inc_en[15:11],   inc_en[0],
                           clr_en[15:11],   clr_en[0]};

endmodule

// File: tb/tb_datapath_bus.sv
// Directed self-checking bench for datapath_bus; register contents are observed through the bus.
module tb_datapath_bus;

    logic        clk;
    logic        rst_n;
    logic [2:0]  alu_op;
    logic [15:0] write_en;
    logic [15:0] inc_en;
    logic [15:0] clr_en;
    logic [3:0]  read_en;
    logic [15:0] im_rdata;
    logic [15:0] dm_rdata;
    logic [15:0] im_addr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_we;
    logic [5:0]  instruction;
    logic [15:0] z;
    logic [15:0] bus;

    int n_asserts = 0;
    int n_fails   = 0;

    datapath_bus #(.DW(16), .OPW(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_op      (alu_op),
        .write_en    (write_en),
        .inc_en      (inc_en),
        .clr_en      (clr_en),
        .read_en     (read_en),
        .im_rdata    (im_rdata),
        .dm_rdata    (dm_rdata),
        .im_addr     (im_addr),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_we       (dm_we),
        .instruction (instruction),
        .z           (z),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] we, input logic [15:0] inc,
                                 input logic [15:0] clr, input logic [3:0] rsel,
                                 input logic [15:0] imd, input logic [15:0] dmd);
        alu_op   = op;
        write_en = we;
        inc_en   = inc;
        clr_en   = clr;
        read_en  = rsel;
        im_rdata = imd;
        dm_rdata = dmd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fails++;
            $display("[TB] FAIL %s: observed 0x%04h, expected 0x%04h", tag, observed, expected);
            $error("[TB] check %s observed 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    task automatic loadReg(input logic [15:0] we_mask, input logic [15:0] value);
        applyStimulus(3'd0, we_mask, 16'h0, 16'h0, 4'd13, value, 16'h0);
        tick();
    endtask

    task automatic readCheck(input string tag, input logic [3:0] code, input logic [15:0] expected);
        applyStimulus(3'd0, 16'h0, 16'h0, 16'h0, code, 16'h0, 16'h0);
        checkOutput(tag, bus, expected);
    endtask

    initial begin
        // Reset held with random control, DM strobe forced on, fetch bit kept off
        rst_n = 1'b0;
        applyStimulus(3'($urandom), (16'($urandom) & 16'hFFF7) | 16'h0800, 16'($urandom),
                      16'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
        tick();
        tick();
        checkOutput("rst_im_addr", im_addr, 16'h0000);
        checkOutput("rst_dm_addr", dm_addr, 16'h0000);
        checkOutput("rst_z", z, 16'h0001);
        checkOutput("rst_dm_we", {15'b0, dm_we}, 16'h0000);
        checkOutput("rst_instr", {10'b0, instruction}, 16'h0000);

        applyStimulus(3'd0, 16'h0, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0);
        rst_n = 1'b1;
        tick();
        tick();
        readCheck("hold_pc", 4'd1, 16'h0000);
        readCheck("hold_ac", 4'd5, 16'h0000);
        readCheck("hold_r1", 4'd7, 16'h0000);
        readCheck("bus_zero_code", 4'd3, 16'h0000);

        // Fetch
        applyStimulus(3'd0, 16'h0008, 16'h0, 16'h0, 4'd13, 16'h0013, 16'h0);
        checkOutput("fetch_instr_same_cycle", {10'b0, instruction}, 16'h0013);
        tick();
        readCheck("fetch_ir", 4'd4, 16'h0013);
        checkOutput("ir_instr", {10'b0, instruction}, 16'h0013);

        // ALU add with PC increment
        loadReg(16'h0010, 16'h0007);
        loadReg(16'h0020, 16'h0005);
        checkOutput("z_nonzero", z, 16'h0000);
        applyStimulus(3'd1, 16'h1000, 16'h0002, 16'h0, 4'd0, 16'h0, 16'h0);
        tick();
        readCheck("alu_add", 4'd5, 16'h000C);
        readCheck("pc_inc", 4'd1, 16'h0001);

        loadReg(16'h0010, 16'h0007);
        applyStimulus(3'd2, 16'h1000, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0);
        tick();
        readCheck("alu_sub", 4'd5, 16'h0002);

        // ALU path beats a same-cycle bus load of AC; op 0 passes AC through
        applyStimulus(3'd0, 16'h1000, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0);
        tick();
        readCheck("alu_none", 4'd5, 16'h0002);
        loadReg(16'h0020, 16'h0100);
        applyStimulus(3'd1, 16'h1010, 16'h0, 16'h0, 4'd13, 16'h5555, 16'h0);
        tick();
        readCheck("alu_over_bus", 4'd5, 16'h0102);

        loadReg(16'h0010, 16'h0100);
        applyStimulus(3'd3, 16'h1000, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0);
        checkOutput("z_before_mult", z, 16'h0000);
        tick();
        checkOutput("z_after_mult", z, 16'h0001);
        readCheck("alu_mult_wrap", 4'd5, 16'h0000);

        loadReg(16'h0010, 16'h8001);
        applyStimulus(3'd4, 16'h1000, 16'h0, 16'h0, 4'd0, 16'h0, 16'h0);
        tick();
        readCheck("alu_lshift", 4'd5, 16'h0002);

        // Store AC to DM at AR
        loadReg(16'h0004, 16'h0040);
        loadReg(16'h0010, 16'hBEEF);
        applyStimulus(3'd0, 16'h0800, 16'h0, 16'h0, 4'd5, 16'h0, 16'h0);
        checkOutput("store_dm_we", {15'b0, dm_we}, 16'h0001);
        checkOutput("store_dm_addr", dm_addr, 16'h0040);
        checkOutput("store_dm_wdata", dm_wdata, 16'hBEEF);
        tick();
        readCheck("store_ac_kept", 4'd5, 16'hBEEF);
        checkOutput("dm_we_idle", {15'b0, dm_we}, 16'h0000);
        applyStimulus(3'd0, 16'h0, 16'h0, 16'h0, 4'd12, 16'h0, 16'h0ABC);
        checkOutput("bus_dm_rdata", bus, 16'h0ABC);

        // Increment wrap and clr > write > inc priority
        loadReg(16'h0010, 16'hFFFF);
        applyStimulus(3'd0, 16'h0, 16'h0010, 16'h0, 4'd0, 16'h0, 16'h0);
        tick();
        readCheck("ac_wrap", 4'd5, 16'h0000);
        checkOutput("ac_wrap_z", z, 16'h0001);
        applyStimulus(3'd0, 16'h0006, 16'h0002, 16'h0006, 4'd13, 16'h7777, 16'h0);
        tick();
        checkOutput("clr_pri_pc", im_addr, 16'h0000);
        checkOutput("clr_pri_ar", dm_addr, 16'h0000);
        applyStimulus(3'd0, 16'h0002, 16'h0002, 16'h0, 4'd13, 16'h0033, 16'h0);
        tick();
        checkOutput("write_over_inc", im_addr, 16'h0033);
        loadReg(16'h0002, 16'hFFFF);
        applyStimulus(3'd0, 16'h0, 16'h0002, 16'h0, 4'd0, 16'h0, 16'h0);
        tick();
        checkOutput("pc_wrap", im_addr, 16'h0000);

        // Moves, multi-destination load, read/modify of same register
        loadReg(16'h0010, 16'h1234);
        applyStimulus(3'd0, 16'h0400, 16'h0, 16'h0, 4'd5, 16'h0, 16'h0);
        tick();
        readCheck("move_r1", 4'd7, 16'h1234);
        applyStimulus(3'd0, 16'h0300, 16'h0, 16'h0, 4'd13, 16'hA5A5, 16'h0);
        tick();
        readCheck("multi_r2", 4'd8, 16'hA5A5);
        readCheck("multi_r3", 4'd9, 16'hA5A5);
        applyStimulus(3'd0, 16'h0002, 16'h0010, 16'h0, 4'd5, 16'h0, 16'h0);
        tick();
        checkOutput("same_reg_old_value", im_addr, 16'h1234);
        readCheck("same_reg_new_value", 4'd5, 16'h1235);

        // Jump through IR, then asynchronous reset mid-cycle
        loadReg(16'h0008, 16'h0025);
        applyStimulus(3'd0, 16'h0002, 16'h0, 16'h0, 4'd4, 16'h0, 16'h0);
        tick();
        checkOutput("jump_pc", im_addr, 16'h0025);
        applyStimulus(3'd0, 16'h0800, 16'h0, 16'h0, 4'd5, 16'h0, 16'h0);
        checkOutput("pre_reset_dm_we", {15'b0, dm_we}, 16'h0001);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pc", im_addr, 16'h0000);
        checkOutput("midrst_dm_we", {15'b0, dm_we}, 16'h0000);
        checkOutput("midrst_z", z, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
